// File: rtl/dual_mem_arbiter.sv
// dual_mem_arbiter: round-robin arbiter and command sequencer for two
// requesters (A, B) sharing a 256x16 dual-port memory.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x  requester command (x = a, b)
//   gnt_x                      command accepted this cycle (combinational)
//   rvalid_x/rdata_x           read return, two cycles after the read grant
//   mem_read/mem_write         memory strobes (never both high)
//   mem_rd_address/mem_wr_address/mem_data_in  memory command fields
//   mem_data_out               registered memory read data
module dual_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_rd_address,
  output logic [ADDR_WIDTH-1:0] mem_wr_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e                  last_served;
  logic                  grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Read tag pipeline: stage 1 tracks the issued read, stage 2 lines up
  // with the memory's registered data.
  logic tag1_valid;
  src_e tag1_owner;
  logic tag2_valid;
  src_e tag2_owner;

  // Round-robin: on contention the requester not served last wins.
  assign gnt_a = ~rst & req_a & (~req_b | (last_served == SRC_B));
  assign gnt_b = ~rst & req_b & (~req_a | (last_served == SRC_A));

  // Granted command fields.
  assign grant     = gnt_a | gnt_b;
  assign sel_we    = gnt_b ? we_b    : we_a;
  assign sel_addr  = gnt_b ? addr_b  : addr_a;
  assign sel_wdata = gnt_b ? wdata_b : wdata_a;

  // Pointer, command stage and tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served    <= SRC_B;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_rd_address <= '0;
      mem_wr_address <= '0;
      mem_data_in    <= '0;
      tag1_valid     <= 1'b0;
      tag1_owner     <= SRC_A;
      tag2_valid     <= 1'b0;
      tag2_owner     <= SRC_A;
    end else begin
      if (gnt_a) begin
        last_served <= SRC_A;
      end else if (gnt_b) begin
        last_served <= SRC_B;
      end

      mem_write <= grant & sel_we;
      mem_read  <= grant & ~sel_we;
      if (grant && sel_we) begin
        mem_wr_address <= sel_addr;
        mem_data_in    <= sel_wdata;
      end
      if (grant && !sel_we) begin
        mem_rd_address <= sel_addr;
      end

      tag1_valid <= grant & ~sel_we;
      tag1_owner <= gnt_b ? SRC_B : SRC_A;
      tag2_valid <= tag1_valid;
      tag2_owner <= tag1_owner;
    end
  end

  // Return path: data routed to the read's owner, zero otherwise.
  assign rvalid_a = tag2_valid & (tag2_owner == SRC_A);
  assign rvalid_b = tag2_valid & (tag2_owner == SRC_B);
  assign rdata_a  = rvalid_a ? mem_data_out : '0;
  assign rdata_b  = rvalid_b ? mem_data_out : '0;

endmodule

// File: tb/tb_dual_mem_arbiter.sv
// Testbench for dual_mem_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level reference model and memory model.
module tb_dual_mem_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_rd_address, mem_wr_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dual_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rd_address(mem_rd_address), .mem_wr_address(mem_wr_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Memory block: registered read, collision zeroes data and drops write.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_read && mem_write) begin
      mem_data_out <= '0;
    end else begin
      if (mem_read)  mem_data_out <= mem[mem_rd_address];
      if (mem_write) mem[mem_wr_address] <= mem_data_in;
    end
  end

  // Reference model: commands applied to ref_mem in grant order; each read
  // result is scheduled into a return slot two cycles after its grant.
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  bit            m_last_b;
  bit            mon_en = 1'b0;
  bit            e_mr, e_mw;
  logic [AW-1:0] e_rda, e_wra;
  logic [DW-1:0] e_din;
  bit            sv [4];
  bit            so [4];
  logic [DW-1:0] sd [4];
  int unsigned   cyc = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin sv[i] = 1'b0; so[i] = 1'b0; sd[i] = '0; end
    forever begin
      bit            xa, xb, xrva, xrvb, g_we;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_data;
      int unsigned   s;
      @(negedge clk);
      s  = cyc % 4;
      xa = !rst && req_a && (!req_b || m_last_b);
      xb = !rst && req_b && (!req_a || !m_last_b);
      if (mon_en) begin
        checks++;
        if (gnt_a !== xa || gnt_b !== xb) begin
          fails++; $display("FAIL mon_gnt cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, gnt_a, gnt_b, xa, xb);
        end
        checks++;
        if (mem_read !== e_mr || mem_write !== e_mw) begin
          fails++; $display("FAIL mon_strobe cyc=%0d got rd=%b wr=%b want rd=%b wr=%b", cyc, mem_read, mem_write, e_mr, e_mw);
        end
        checks++;
        if (mem_rd_address !== e_rda || mem_wr_address !== e_wra || mem_data_in !== e_din) begin
          fails++; $display("FAIL mon_cmd cyc=%0d got ra=%h wa=%h d=%h want ra=%h wa=%h d=%h", cyc,
                            mem_rd_address, mem_wr_address, mem_data_in, e_rda, e_wra, e_din);
        end
        xrva = sv[s] && !so[s];
        xrvb = sv[s] && so[s];
        checks++;
        if (rvalid_a !== xrva || rdata_a !== (xrva ? sd[s] : 16'h0)) begin
          fails++; $display("FAIL mon_ret_a cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, rvalid_a, rdata_a, xrva, xrva ? sd[s] : 16'h0);
        end
        checks++;
        if (rvalid_b !== xrvb || rdata_b !== (xrvb ? sd[s] : 16'h0)) begin
          fails++; $display("FAIL mon_ret_b cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, rvalid_b, rdata_b, xrvb, xrvb ? sd[s] : 16'h0);
        end
        checks++;
        if ((mem_read & mem_write) !== 1'b0) begin
          fails++; $display("FAIL mon_collision cyc=%0d got rd&wr=%b want 0", cyc, mem_read & mem_write);
        end
      end
      sv[s] = 1'b0;
      if (rst) begin
        m_last_b = 1'b1;
        e_mr = 1'b0; e_mw = 1'b0; e_rda = '0; e_wra = '0; e_din = '0;
        sv[(cyc + 1) % 4] = 1'b0;
        sv[(cyc + 2) % 4] = 1'b0;
        mon_en = 1'b1;
      end else if (mon_en) begin
        if (xa || xb) begin
          g_we   = xb ? we_b : we_a;
          g_addr = xb ? addr_b : addr_a;
          g_data = xb ? wdata_b : wdata_a;
          if (g_we) begin
            ref_mem[g_addr] = g_data;
            e_mw = 1'b1; e_mr = 1'b0; e_wra = g_addr; e_din = g_data;
          end else begin
            e_mr = 1'b1; e_mw = 1'b0; e_rda = g_addr;
            sv[(cyc + 2) % 4] = 1'b1;
            so[(cyc + 2) % 4] = xb;
            sd[(cyc + 2) % 4] = ref_mem[g_addr];
          end
          m_last_b = xb;
        end else begin
          e_mr = 1'b0; e_mw = 1'b0;
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      fails++; $display("FAIL reset_gnt got a=%b b=%b want 0 0", gnt_a, gnt_b);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_rd_address !== 8'h0 ||
        mem_wr_address !== 8'h0 || mem_data_in !== 16'h0) begin
      fails++; $display("FAIL reset_cmd got rd=%b wr=%b ra=%h wa=%h d=%h want all 0",
                        mem_read, mem_write, mem_rd_address, mem_wr_address, mem_data_in);
    end
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata_a !== 16'h0 || rdata_b !== 16'h0) begin
      fails++; $display("FAIL reset_ret got va=%b vb=%b da=%h db=%h want all 0", rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
    next_cycle();
    req_a = 1'b0; req_b = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single_write_read();
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'h10; wdata_a = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin fails++; $display("FAIL swr_wgnt got %b want 1", gnt_a); end
    next_cycle();
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wr_address !== 8'h10 || mem_data_in !== 16'hBEEF) begin
      fails++; $display("FAIL swr_wcmd got wr=%b rd=%b wa=%h d=%h want 1 0 10 beef", mem_write, mem_read, mem_wr_address, mem_data_in);
    end
    next_cycle();
    req_a = 1'b1; we_a = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin fails++; $display("FAIL swr_rgnt got %b want 1", gnt_a); end
    next_cycle();
    req_a = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'hBEEF || rvalid_b !== 1'b0) begin
      fails++; $display("FAIL swr_rdata got va=%b da=%h vb=%b want 1 beef 0", rvalid_a, rdata_a, rvalid_b);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    req_b = 1'b1; we_b = 1'b1; addr_b = 8'h20; wdata_b = 16'h5A5A;
    next_cycle();
    req_b = 1'b0;
    next_cycle();
    do_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'h20;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin fails++; $display("FAIL cont_first got a=%b b=%b want 1 0", gnt_a, gnt_b); end
    next_cycle();
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b1) begin fails++; $display("FAIL cont_second got b=%b want 1", gnt_b); end
    next_cycle();
    req_b = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 16'hBEEF || rvalid_b !== 1'b0) begin
      fails++; $display("FAIL cont_ret_a got va=%b da=%h vb=%b want 1 beef 0", rvalid_a, rdata_a, rvalid_b);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h5A5A || rvalid_a !== 1'b0) begin
      fails++; $display("FAIL cont_ret_b got vb=%b db=%h va=%b want 1 5a5a 0", rvalid_b, rdata_b, rvalid_a);
    end
    next_cycle();
  endtask

  task automatic test_sustained();
    do_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'($urandom_range(0, 255));
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_a !== (i % 2 == 0) || gnt_b !== (i % 2 == 1) || (mem_read & mem_write) !== 1'b0) begin
        fails++; $display("FAIL sustained_%0d got a=%b b=%b rw=%b want a=%b b=%b rw=0", i, gnt_a, gnt_b,
                          mem_read & mem_write, i % 2 == 0, i % 2 == 1);
      end
      next_cycle();
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_raw();
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'hFF; wdata_a = 16'h1234;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin fails++; $display("FAIL raw_wgnt got %b want 1", gnt_a); end
    next_cycle();
    req_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 8'hFF;
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b1) begin fails++; $display("FAIL raw_rgnt got %b want 1", gnt_b); end
    next_cycle();
    req_b = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'h1234) begin
      fails++; $display("FAIL raw_data got vb=%b db=%h want 1 1234", rvalid_b, rdata_b);
    end
    next_cycle();
  endtask

  task automatic test_single_b();
    for (int i = 0; i < 3; i++) begin
      req_b = 1'b1; we_b = 1'b1; addr_b = 8'($urandom_range(0, 255)); wdata_b = 16'($urandom);
      @(negedge clk);
      checks++;
      if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin fails++; $display("FAIL single_b_%0d got b=%b a=%b want 1 0", i, gnt_b, gnt_a); end
      next_cycle();
    end
    req_b = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL single_b_idle got rd=%b wr=%b want 0 0", mem_read, mem_write);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin fails++; $display("FAIL rmr_gnt got %b want 1", gnt_a); end
    next_cycle();
    req_a = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid_a !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        fails++; $display("FAIL rmr_drop_%0d got va=%b rd=%b wr=%b want 0 0 0", i, rvalid_a, mem_read, mem_write);
      end
      next_cycle();
    end
    req_a = 1'b1; we_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 8'h20;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin fails++; $display("FAIL rmr_after got a=%b b=%b want 1 0", gnt_a, gnt_b); end
    next_cycle();
    req_a = 1'b0;
    next_cycle();
    req_b = 1'b0;
    repeat (3) next_cycle();
  endtask

  // Random traffic with handshake hold; occasional resets mid-stream.
  task automatic test_random();
    bit ga, gb;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ga = gnt_a; gb = gnt_b;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 63) == 0);
      if (!(req_a && !ga)) begin
        req_a = ($urandom_range(0, 3) != 0); we_a = $urandom_range(0, 1) == 1;
        addr_a = 8'($urandom_range(0, 15)); wdata_a = 16'($urandom);
      end
      if (!(req_b && !gb)) begin
        req_b = ($urandom_range(0, 3) != 0); we_b = $urandom_range(0, 1) == 1;
        addr_b = 8'($urandom_range(0, 15)); wdata_b = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (4) next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_write_read();
    test_contention();
    test_sustained();
    test_raw();
    test_single_b();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
